transposed_conv2: RTL and testbench

TRANSPOSED_CONV2 -- requirements
Module: transposed_conv2

---
 rtl/transposed_conv2.sv | 114 +++++++++++
 tb/tb_transposed_conv2.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/transposed_conv2.sv
// Stride-1 transposed convolution, one multiply-accumulate per cycle.
// Inputs are latched at start; the result map and overflow hold from done until the next job clears them.
module transposed_conv2 #(
    parameter int SIZE      = 3,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 8
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 start,
    input  logic [WIDTH_BIT-1:0] inpMatrixI [SIZE][SIZE],
    input  logic [WIDTH_BIT-1:0] kernel     [SIZEKer][SIZEKer],
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [WIDTH_BIT-1:0] deconvOut  [SIZE+SIZEKer-1][SIZE+SIZEKer-1]
);

    localparam int OUT = SIZE + SIZEKer - 1;
    localparam int IW  = (SIZE    > 1) ? $clog2(SIZE)    : 1;
    localparam int KW  = (SIZEKer > 1) ? $clog2(SIZEKer) : 1;
    localparam int OW  = (OUT     > 1) ? $clog2(OUT)     : 1;
    localparam int PW  = 2 * WIDTH_BIT;

    typedef enum logic [1:0] {IDLE, CLEAR, SCATTER, DONE} state_t;

    state_t               state;
    logic [WIDTH_BIT-1:0] inp_q [SIZE][SIZE];
    logic [WIDTH_BIT-1:0] ker_q [SIZEKer][SIZEKer];
    logic [IW-1:0]        ci, cj;
    logic [KW-1:0]        cki, ckj;

    logic [OW-1:0]        row, col;
    logic [PW-1:0]        prod;
    logic [PW:0]          acc;
    logic                 last;

    always_comb begin
        row  = OW'(ci) + OW'(cki);
        col  = OW'(cj) + OW'(ckj);
        prod = PW'(inp_q[ci][cj]) * PW'(ker_q[cki][ckj]);
        // Full-width sum so a wrap of either the product or the accumulation is visible
        acc  = (PW+1)'(prod) + (PW+1)'(deconvOut[row][col]);
        last = (ci  == IW'(SIZE - 1))    && (cj  == IW'(SIZE - 1)) &&
               (cki == KW'(SIZEKer - 1)) && (ckj == KW'(SIZEKer - 1));
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            deconvOut <= '{default: '0};
            inp_q     <= '{default: '0};
            ker_q     <= '{default: '0};
            ci        <= '0;
            cj        <= '0;
            cki       <= '0;
            ckj       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        inp_q <= inpMatrixI;
                        ker_q <= kernel;
                        busy  <= 1'b1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    deconvOut <= '{default: '0};
                    overflow  <= 1'b0;
                    ci        <= '0;
                    cj        <= '0;
                    cki       <= '0;
                    ckj       <= '0;
                    state     <= SCATTER;
                end
                SCATTER: begin
                    deconvOut[row][col] <= acc[WIDTH_BIT-1:0];
                    if (|acc[PW:WIDTH_BIT]) overflow <= 1'b1;
                    if (ckj == KW'(SIZEKer - 1)) begin
                        ckj <= '0;
                        if (cki == KW'(SIZEKer - 1)) begin
                            cki <= '0;
                            if (cj == IW'(SIZE - 1)) begin
                                cj <= '0;
                                ci <= (ci == IW'(SIZE - 1)) ? '0 : ci + IW'(1);
                            end else begin
                                cj <= cj + IW'(1);
                            end
                        end else begin
                            cki <= cki + KW'(1);
                        end
                    end else begin
                        ckj <= ckj + KW'(1);
                    end
                    if (last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transposed_conv2.sv
// Directed bench for transposed_conv2: table of jobs with hand-computed spot values,
// a reference sum model for the full map, and sequences for restart, reset and input changes.
module tb_transposed_conv2;

    localparam int S = 3;
    localparam int K = 3;
    localparam int O = S + K - 1;

    typedef logic [S-1:0][S-1:0][7:0] mat_t;
    typedef logic [K-1:0][K-1:0][7:0] kmat_t;
    typedef logic [O-1:0][O-1:0][7:0] omat_t;

    typedef struct {
        mat_t              m;
        kmat_t             k;
        logic [4:0][2:0]   sr;
        logic [4:0][2:0]   sc;
        logic [4:0][7:0]   sv;
        bit                ov;
    } vec_t;

    logic       clock = 1'b0;
    logic       nreset;
    logic       start;
    logic [7:0] inp_u [S][S];
    logic [7:0] ker_u [K][K];
    logic       busy, done, overflow;
    logic [7:0] out_u [O][O];

    int   nvec = 0;
    int   nbad = 0;
    int   done_cnt = 0;
    vec_t vecs [7];

    transposed_conv2 #(.SIZE(S), .SIZEKer(K), .WIDTH_BIT(8)) dut (
        .clock(clock), .nreset(nreset), .start(start),
        .inpMatrixI(inp_u), .kernel(ker_u),
        .busy(busy), .done(done), .overflow(overflow), .deconvOut(out_u)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic mat_t mfill(input logic [7:0] v);
        mat_t r;
        for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) r[i][j] = v;
        return r;
    endfunction

    function automatic kmat_t kfill(input logic [7:0] v);
        kmat_t r;
        for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) r[i][j] = v;
        return r;
    endfunction

    // Overflow occurs exactly when some element's untruncated sum of products reaches 256
    function automatic void model(input mat_t m, input kmat_t k, output omat_t e, output bit ov);
        int sum [O][O];
        for (int r = 0; r < O; r++) for (int c = 0; c < O; c++) sum[r][c] = 0;
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++)
                for (int ki = 0; ki < K; ki++)
                    for (int kj = 0; kj < K; kj++)
                        sum[i+ki][j+kj] += int'(m[i][j]) * int'(k[ki][kj]);
        ov = 1'b0;
        for (int r = 0; r < O; r++)
            for (int c = 0; c < O; c++) begin
                e[r][c] = 8'(sum[r][c]);
                if (sum[r][c] >= 256) ov = 1'b1;
            end
    endfunction

    task automatic set_spot(input int v, input int s, input int r, input int c, input int val);
        vecs[v].sr[s] = 3'(r);
        vecs[v].sc[s] = 3'(c);
        vecs[v].sv[s] = 8'(val);
    endtask

    task automatic load(input mat_t m, input kmat_t k);
        for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) inp_u[i][j] = m[i][j];
        for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) ker_u[i][j] = k[i][j];
    endtask

    // Cycle 1 is the CLEAR cycle right after the accepting edge; done is expected in cycle 83
    task automatic run_job(input mat_t m, input kmat_t k, input int pa, input int pb,
                           input bit pulse_in_done, input bit perturb);
        int cyc;
        int lat;
        load(m, k);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        cyc = 1;
        lat = 0;
        check("busy_after_accept", busy, 1);
        while (lat == 0 && cyc < 200) begin
            @(negedge clock);
            start = (cyc == pa) || (cyc == pb);
            if (perturb && cyc == 10) load(mfill(8'd200), kfill(8'd7));
            @(posedge clock);
            #1;
            cyc++;
            if (done) lat = cyc;
        end
        check("done_cycle", lat, 83);
        @(negedge clock);
        start = pulse_in_done;
        @(posedge clock);
        #1;
        check("busy_after_done", busy, 0);
        check("done_pulse_width", done, 0);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_result(input int v);
        omat_t e;
        bit    eo;
        int    bad;
        model(vecs[v].m, vecs[v].k, e, eo);
        check($sformatf("v%0d_overflow", v), overflow, vecs[v].ov);
        for (int s = 0; s < 5; s++)
            check($sformatf("v%0d_out[%0d][%0d]", v, vecs[v].sr[s], vecs[v].sc[s]),
                  out_u[vecs[v].sr[s]][vecs[v].sc[s]], vecs[v].sv[s]);
        bad = 0;
        for (int r = 0; r < O; r++)
            for (int c = 0; c < O; c++)
                if (out_u[r][c] !== e[r][c]) begin
                    if (bad == 0)
                        $display("FAIL v%0d_map[%0d][%0d]: got %0d, expected %0d",
                                 v, r, c, out_u[r][c], e[r][c]);
                    bad++;
                end
        check($sformatf("v%0d_map_mismatches", v), bad, 0);
    endtask

    task automatic check_all_zero(input string name);
        int nz = 0;
        for (int r = 0; r < O; r++) for (int c = 0; c < O; c++) if (out_u[r][c] !== 8'd0) nz++;
        check(name, nz, 0);
    endtask

    initial begin
        kmat_t kr;
        mat_t  mi;

        for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) kr[i][j] = 8'(i * K + j + 1);

        vecs[0].m = mfill(8'd1);   vecs[0].k = kfill(8'd1);   vecs[0].ov = 1'b0;
        set_spot(0, 0, 0, 0, 1); set_spot(0, 1, 0, 1, 2); set_spot(0, 2, 1, 1, 4);
        set_spot(0, 3, 2, 2, 9); set_spot(0, 4, 4, 4, 1);

        mi = mfill(8'd0); mi[0][0] = 8'd5;
        vecs[1].m = mi;            vecs[1].k = kr;            vecs[1].ov = 1'b0;
        set_spot(1, 0, 0, 0, 5); set_spot(1, 1, 0, 1, 10); set_spot(1, 2, 0, 2, 15);
        set_spot(1, 3, 2, 2, 45); set_spot(1, 4, 3, 3, 0);

        vecs[2].m = mfill(8'd255); vecs[2].k = kfill(8'd255); vecs[2].ov = 1'b1;
        set_spot(2, 0, 0, 0, 1); set_spot(2, 1, 0, 1, 2); set_spot(2, 2, 1, 1, 4);
        set_spot(2, 3, 2, 2, 9); set_spot(2, 4, 4, 4, 1);

        mi = mfill(8'd0); mi[2][2] = 8'd3;
        vecs[3].m = mi;            vecs[3].k = kfill(8'd2);   vecs[3].ov = 1'b0;
        set_spot(3, 0, 4, 4, 6); set_spot(3, 1, 2, 2, 6); set_spot(3, 2, 3, 2, 6);
        set_spot(3, 3, 0, 0, 0); set_spot(3, 4, 1, 4, 0);

        vecs[4].m = mfill(8'd16);  vecs[4].k = kfill(8'd16);  vecs[4].ov = 1'b1;
        set_spot(4, 0, 0, 0, 0); set_spot(4, 1, 2, 2, 0); set_spot(4, 2, 4, 4, 0);
        set_spot(4, 3, 1, 3, 0); set_spot(4, 4, 3, 1, 0);

        vecs[5].m = mfill(8'd1);   vecs[5].k = kfill(8'd0);   vecs[5].k[0][0] = 8'd255;
        vecs[5].ov = 1'b0;
        set_spot(5, 0, 0, 0, 255); set_spot(5, 1, 2, 2, 255); set_spot(5, 2, 0, 2, 255);
        set_spot(5, 3, 3, 3, 0); set_spot(5, 4, 2, 3, 0);

        mi = mfill(8'd0); mi[0][0] = 8'd1; mi[0][1] = 8'd1;
        vecs[6].m = mi;            vecs[6].k = kfill(8'd0);   vecs[6].ov = 1'b1;
        vecs[6].k[0][0] = 8'd128;  vecs[6].k[0][1] = 8'd128;
        set_spot(6, 0, 0, 0, 128); set_spot(6, 1, 0, 1, 0); set_spot(6, 2, 0, 2, 128);
        set_spot(6, 3, 1, 0, 0); set_spot(6, 4, 4, 4, 0);

        nreset = 1'b0;
        start  = 1'b0;
        load(mfill(8'd0), kfill(8'd0));
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_overflow", overflow, 0);
        check_all_zero("reset_map_nonzero");
        @(negedge clock);
        nreset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].m, vecs[v].k, 0, 0, 1'b0, 1'b0);
            check_result(v);
        end

        // Restart attempts mid-scatter, on the last MAC cycle and in DONE
        done_cnt = 0;
        run_job(vecs[0].m, vecs[0].k, 5, 82, 1'b1, 1'b0);
        check_result(0);
        repeat (4) @(posedge clock);
        #1;
        check("ignored_start_busy", busy, 0);
        check("ignored_start_done_count", done_cnt, 1);
        check_result(0);

        // Reset asserted in the middle of scatter
        load(vecs[2].m, vecs[2].k);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        done_cnt = 0;
        repeat (39) @(posedge clock);
        @(negedge clock);
        check("midjob_overflow_before_reset", overflow, 1);
        nreset = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_overflow", overflow, 0);
        check_all_zero("midreset_map_nonzero");
        repeat (3) @(posedge clock);
        @(negedge clock);
        nreset = 1'b1;
        check("midreset_no_done", done_cnt, 0);
        run_job(vecs[1].m, vecs[1].k, 0, 0, 1'b0, 1'b0);
        check_result(1);

        // Inputs changed while the job runs must not disturb the latched copy
        run_job(vecs[1].m, vecs[1].k, 0, 0, 1'b0, 1'b1);
        check_result(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
